// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit types, output port indices and the XY routing function.
package noc_pkg;

  localparam int COORD_W_DEFAULT = 4;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_EAST  = 1;
  localparam int PORT_WEST  = 2;
  localparam int PORT_NORTH = 3;
  localparam int PORT_SOUTH = 4;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FWD  = 1'b1
  } ipm_state_e;

  // X is resolved before Y; a destination equal to this router goes LOCAL.
  function automatic logic [4:0] route_xy(input int dx, input int dy, input int lx, input int ly);
    logic [4:0] r;
    r = '0;
    if (dx > lx)      r[PORT_EAST]  = 1'b1;
    else if (dx < lx) r[PORT_WEST]  = 1'b1;
    else if (dy > ly) r[PORT_NORTH] = 1'b1;
    else if (dy < ly) r[PORT_SOUTH] = 1'b1;
    else              r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ipm_sync_port_fifo.sv
// Flit FIFO for the router input port: registered head (no fall-through), async active-low reset.
module ipm_flit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ipm_sync_port.sv
// Buffered wormhole input port with XY routing; IPM_ROUTE_CHECK_EN enables flit-type protocol checking.
module ipm_sync_port
  import noc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int OUTPORTS  = 5,
  parameter int COORD_W   = COORD_W_DEFAULT,
  parameter int LocationX = 2,
  parameter int LocationY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_up_i,
  input  logic [WIDTH-1:0]          Data_up_i,
  output logic                      ready_up_o,
  output logic [OUTPORTS-1:0]       valid_dw_o,
  output logic [OUTPORTS*WIDTH-1:0] Data_dw_o,
  input  logic [OUTPORTS-1:0]       ready_dw_i,
  output logic [OUTPORTS-1:0]       PacketEnable_dw_o,
  output logic                      err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]       fifo_count;
  logic [WIDTH-1:0]    head;
  flit_type_e          head_type;
  logic [COORD_W-1:0]  dest_x, dest_y;
  logic [OUTPORTS-1:0] head_route;

  logic                rdy_q;
  ipm_state_e          state_q, state_d;
  logic [OUTPORTS-1:0] route_q, route_d;
  logic                first_q, first_d;

  // Upstream ready stays low until the first edge after reset release.
  assign ready_up_o = rdy_q && (fifo_count != FULL_CNT);
  assign fifo_push  = valid_up_i && rdy_q && !fifo_full;

  ipm_flit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (Data_up_i),
    .pop   (fifo_pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign head_type  = flit_type_e'(head[WIDTH-1 -: 2]);
  assign dest_x     = head[COORD_W-1:0];
  assign dest_y     = head[2*COORD_W-1:COORD_W];
  assign head_route = route_xy(32'(dest_x), 32'(dest_y), LocationX, LocationY);

  assign Data_dw_o         = fifo_empty ? '0 : {OUTPORTS{head}};
  assign PacketEnable_dw_o = route_q;

`ifdef IPM_ROUTE_CHECK_EN
  logic err_q, err_d, is_head;
  assign is_head = (head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE);
  assign err_o   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    first_d    = first_q;
    fifo_pop   = 1'b0;
    valid_dw_o = '0;
`ifdef IPM_ROUTE_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
`ifdef IPM_ROUTE_CHECK_EN
          if (is_head) begin
            route_d = head_route;
            first_d = 1'b1;
            state_d = S_FWD;
          end else begin
            fifo_pop = 1'b1;
            err_d    = 1'b1;
          end
`else
          route_d = head_route;
          first_d = 1'b1;
          state_d = S_FWD;
`endif
        end
      end
      S_FWD: begin
        valid_dw_o = route_q & {OUTPORTS{!fifo_empty}};
        if ((valid_dw_o & ready_dw_i) != '0) begin
          fifo_pop = 1'b1;
          first_d  = 1'b0;
`ifdef IPM_ROUTE_CHECK_EN
          if (!first_q && is_head) err_d = 1'b1;
`endif
          // A SINGLE closes the packet only when it is the flit that opened it.
          if (head_type == FLIT_TAIL || (head_type == FLIT_SINGLE && first_q)) begin
            route_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        route_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q   <= 1'b0;
      state_q <= S_IDLE;
      route_q <= '0;
      first_q <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      route_q <= route_d;
      first_q <= first_d;
    end
  end

endmodule
